// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: sequences a combinational ROM and buffers {pc, inst} pairs
// in a prefetch queue toward decode. Define FETCH_BYPASS_EN to present ROM data directly when empty.
module inst_fetch_ctrl #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        if_ready_i,
   output logic        if_valid_o,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_inst_o,
   output logic        rom_ce_o,
   output logic [31:0] rom_addr_o,
   input  logic [31:0] rom_inst_i
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic        enable_signal  = 1'b1;
   localparam logic        disable_signal = 1'b0;
   localparam logic [31:0] zero_word      = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [31:0]        fetch_pc;
   logic [31:0]        q_pc   [DEPTH];
   logic [31:0]        q_inst [DEPTH];
   logic [PTR_W-1:0]   rd_ptr, wr_ptr;
   logic [CNT_W-1:0]   count;
   logic [31:0]        hold_pc, hold_inst, hold_addr;
   logic [31:0]        redirect_target;
   logic               q_nonempty;
   logic               push, pop, bypass_hit;

   assign redirect_target = redirect_pc_i & ~32'h3;
   assign q_nonempty      = (count != '0);

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt  = state;
      rom_ce_o   = disable_signal;
      rom_addr_o = hold_addr;
      push       = 1'b0;
      bypass_hit = 1'b0;
      if_valid_o = q_nonempty;
      if_pc_o    = hold_pc;
      if_inst_o  = hold_inst;
      if (q_nonempty) begin
         if_pc_o   = q_pc[rd_ptr];
         if_inst_o = q_inst[rd_ptr];
      end
      pop = q_nonempty && if_ready_i;

      case (state)
         S_IDLE: state_nxt = S_FETCH;
         S_FETCH: begin
            rom_ce_o   = enable_signal;
            rom_addr_o = fetch_pc;
            if (!redirect_i) begin
`ifdef FETCH_BYPASS_EN
               if (!q_nonempty) begin
                  bypass_hit = 1'b1;
                  if_valid_o = 1'b1;
                  if_pc_o    = fetch_pc;
                  if_inst_o  = rom_inst_i;
               end
`endif
               // A bypassed word taken by decode this cycle never enters the queue.
               push = !(bypass_hit && if_ready_i);
               if (push && !pop && count == CNT_W'(DEPTH - 1))
                  state_nxt = S_FULL;
            end
         end
         S_FULL: begin
            if (redirect_i || pop) state_nxt = S_FETCH;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc  <= RESET_PC;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         hold_pc   <= 32'h0;
         hold_inst <= zero_word;
         hold_addr <= 32'h0;
      end else begin
         if (if_valid_o) begin
            hold_pc   <= if_pc_o;
            hold_inst <= if_inst_o;
         end
         hold_addr <= rom_addr_o;

         if (redirect_i) begin
            // Flush wins over any push; a same-cycle pop is already captured in hold_*.
            fetch_pc <= redirect_target;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
         end else begin
            if (state == S_FETCH) fetch_pc <= fetch_pc + 32'd4;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
         end
      end
   end

   // NOTE: queue storage is not reset; count and pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[wr_ptr]   <= fetch_pc;
         q_inst[wr_ptr] <= rom_inst_i;
      end
   end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: a primary instance at RESET_PC 0 and a second one
// starting at 32'hFFFF_FFF8 for the address wrap; ROM word = address ^ 32'hA5A5_0000.
module tb_inst_fetch_ctrl;

   localparam logic [31:0] ROM_KEY = 32'hA5A5_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        ready, valid, ce;
   logic [31:0] pc, inst, addr, rom_data;
   logic        ready_w, valid_w, ce_w;
   logic [31:0] pc_w, inst_w, addr_w, rom_w;

   int   n_pass  = 0;
   int   n_total = 0;
   exp_t sb[$];

   logic [31:0] wrap_pc   [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
   logic [31:0] wrap_inst [4] = '{32'h5A5A_FFF8, 32'h5A5A_FFFC, 32'hA5A5_0000, 32'hA5A5_0004};

   always #5 clk = ~clk;

   assign rom_data = addr ^ ROM_KEY;
   assign rom_w    = addr_w ^ ROM_KEY;

   inst_fetch_ctrl #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .if_ready_i    (ready),
      .if_valid_o    (valid),
      .if_pc_o       (pc),
      .if_inst_o     (inst),
      .rom_ce_o      (ce),
      .rom_addr_o    (addr),
      .rom_inst_i    (rom_data)
   );

   inst_fetch_ctrl #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clk           (clk),
      .rst           (rst),
      .redirect_i    (1'b0),
      .redirect_pc_i (32'h0),
      .if_ready_i    (ready_w),
      .if_valid_o    (valid_w),
      .if_pc_o       (pc_w),
      .if_inst_o     (inst_w),
      .rom_ce_o      (ce_w),
      .rom_addr_o    (addr_w),
      .rom_inst_i    (rom_w)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_pc(input logic [31:0] p);
      sb.push_back('{pc: p, inst: p ^ ROM_KEY});
   endtask

   task automatic check_reset_outputs();
      check("rst_valid",   valid,   32'h0);
      check("rst_pc",      pc,      32'h0);
      check("rst_inst",    inst,    32'h0);
      check("rst_ce",      ce,      32'h0);
      check("rst_addr",    addr,    32'h0);
      check("rst_w_valid", valid_w, 32'h0);
      check("rst_w_pc",    pc_w,    32'h0);
      check("rst_w_inst",  inst_w,  32'h0);
      check("rst_w_ce",    ce_w,    32'h0);
      check("rst_w_addr",  addr_w,  32'h0);
   endtask

   // Three reset cycles with random inputs; returns just before release edge E0.
   task automatic do_reset(input logic rdy, input logic rdy_w);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_reset_outputs();
         redirect    = 1'($urandom);
         redirect_pc = $urandom;
         ready       = 1'($urandom);
         ready_w     = 1'($urandom);
      end
      rst         = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      ready       = rdy;
      ready_w     = rdy_w;
   endtask

   // Monitor: every handshake on the primary instance must match the next scoreboard entry.
   always @(negedge clk) begin
      if (rst === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL sb_unexpected: accepted pc %h inst %h, nothing expected", pc, inst);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_pc",   pc,   e.pc);
            check("sb_inst", inst, e.inst);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b0; ready_w = 1'b0;

      // Reset and streaming at one instruction per cycle.
      do_reset(1'b1, 1'b0);
      check("idle_ce", ce, 32'h0);
      expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
      step();                                   // after E0
      check("first_ce",    ce,    32'h1);
      check("first_addr",  addr,  32'h0);
      check("first_valid", valid, 32'h0);
      step();                                   // after E1
      check("stream_valid", valid, 32'h1);
      repeat (3) step();                        // after E4
      step();                                   // after E5
      ready = 1'b0;
      check("stream_drained", sb.size(), 32'd0);

      // Backpressure: fill to DEPTH, then release.
      do_reset(1'b0, 1'b0);
      step();
      check("bp_fetch_ce", ce, 32'h1);
      repeat (4) step();                        // after E4
      check("bp_full_ce",    ce,    32'h0);
      check("bp_full_addr",  addr,  32'hC);
      check("bp_full_valid", valid, 32'h1);
      check("bp_head_pc",    pc,    32'h0);
      repeat (3) step();                        // after E7
      check("bp_still_full", ce, 32'h0);
      for (int i = 0; i < 7; i++) expect_pc(32'(i * 4));
      ready = 1'b1;
      repeat (7) step();
      ready = 1'b0;
      check("bp_drained", sb.size(), 32'd0);

      // Redirect flush with three entries queued.
      do_reset(1'b0, 1'b0);
      repeat (4) step();                        // after E3
      check("flush_pre_valid", valid, 32'h1);
      redirect = 1'b1; redirect_pc = 32'h103;
      step();                                   // after E4
      redirect = 1'b0; ready = 1'b1;
      expect_pc(32'h100); expect_pc(32'h104);
      check("flush_valid", valid, 32'h0);
      check("flush_addr",  addr,  32'h100);
      check("flush_ce",    ce,    32'h1);
      step();
      check("flush_target_valid", valid, 32'h1);
      step(); step();
      ready = 1'b0;
      check("flush_drained", sb.size(), 32'd0);

      // Redirect in the same cycle as accepting PC 8.
      do_reset(1'b0, 1'b0);
      repeat (4) step();                        // after E3
      expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
      expect_pc(32'h40); expect_pc(32'h44);
      ready = 1'b1;
      step(); step();                           // after E5
      check("rp_head_pc", pc, 32'h8);
      redirect = 1'b1; redirect_pc = 32'h40;
      step();                                   // after E6
      redirect = 1'b0;
      check("rp_valid",     valid, 32'h0);
      check("rp_hold_pc",   pc,    32'h8);
      check("rp_hold_inst", inst,  32'hA5A5_0008);
      check("rp_addr",      addr,  32'h40);
      repeat (3) step();
      ready = 1'b0;
      check("rp_drained", sb.size(), 32'd0);

      // Address wrap from RESET_PC 32'hFFFF_FFF8, then reset while both instances are full.
      do_reset(1'b0, 1'b1);
      step();
      check("w_first_addr", addr_w, 32'hFFFF_FFF8);
      check("w_first_ce",   ce_w,   32'h1);
      for (int i = 0; i < 4; i++) begin
         step();
         check("w_valid", valid_w, 32'h1);
         check("w_pc",    pc_w,    wrap_pc[i]);
         check("w_inst",  inst_w,  wrap_inst[i]);
      end
      ready_w = 1'b0;
      repeat (4) step();
      check("w_full_ce",    ce_w,    32'h0);
      check("w_full_valid", valid_w, 32'h1);
      check("m_full_ce",    ce,      32'h0);
      check("m_full_valid", valid,   32'h1);
      do_reset(1'b0, 1'b0);
      check("final_drained", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
